// File: rtl/mem_ctrl_seq.sv
// mem_ctrl_seq: per batch, pulses core_start, waits for a rising all-ops-ended flag, snapshots core results, writes them to memory one word at a time.
// Latency: start -> core_start 1 cycle; flag edge -> first mem_wr 1 cycle; done 2 cycles after the last mem_ack.
// Backpressure: mem_wr/mem_addr/mem_wdata hold until mem_ack. Optional WAIT_END watchdog via `define MEM_CTRL_SEQ_TIMEOUT_EN.
module mem_ctrl_seq #(
  parameter int NUM_CORES      = 4,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int BASE_ADDR      = 0,
  parameter int NUM_BATCHES    = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic                                                   state_ctrl_signal,
  input  logic [NUM_CORES*DATA_W-1:0]                            core_result,
  output logic                                                   core_start,
  output logic [ADDR_W-1:0]                                      mem_addr,
  output logic [DATA_W-1:0]                                      mem_wdata,
  output logic                                                   mem_wr,
  input  logic                                                   mem_ack,
  output logic [((NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1)-1:0] batch_idx,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   err
);

  localparam int BW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Degenerate parameter sets have no meaningful sequence; stop elaboration.
  if (NUM_CORES < 1 || NUM_BATCHES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_ctrl_seq: NUM_CORES, NUM_BATCHES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_END, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                flag_q, flag_rise, wd_expire;
  logic [CW-1:0]       core_idx, core_idx_d, core_inc;
  logic [BW-1:0]       batch_idx_d;
  logic [DATA_W-1:0]   snap [NUM_CORES];
  logic                snap_ld, last_core, last_batch;
  logic                core_start_d, busy_d, done_d, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  // Word address wraps naturally at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [BW-1:0] b, input logic [CW-1:0] c);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(b) * ADDR_W'(NUM_CORES) + ADDR_W'(c);
  endfunction

  // Only a fresh low->high transition ends a batch; a flag left high never re-triggers.
  assign flag_rise  = state_ctrl_signal & ~flag_q;
  assign core_inc   = core_idx + CW'(1);
  assign last_core  = (core_idx == CW'(NUM_CORES - 1));
  assign last_batch = (batch_idx == BW'(NUM_BATCHES - 1));

`ifdef MEM_CTRL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;

  assign wd_expire = (state == S_WAIT_END) && !flag_rise && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT_END cycles (held at 0 elsewhere); err is sticky until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != S_WAIT_END) wd_cnt <= '0;
      else if (!flag_rise)     wd_cnt <= wd_cnt + TW'(1);
      if (state == S_IDLE && start) err <= 1'b0;
      else if (wd_expire)           err <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LAUNCH;
      S_LAUNCH:   state_nxt = S_WAIT_END;
      S_WAIT_END: if (flag_rise) state_nxt = S_WRITE;
                  else if (wd_expire) state_nxt = S_DONE;
      S_WRITE:    if (mem_ack && last_core) state_nxt = S_NEXT;
      S_NEXT:     state_nxt = last_batch ? S_DONE : S_LAUNCH;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath decode: values computed here are registered on the next edge.
  always_comb begin
    core_start_d = (state_nxt == S_LAUNCH);
    busy_d       = (state_nxt != S_IDLE);
    done_d       = (state_nxt == S_DONE);
    mem_wr_d     = (state_nxt == S_WRITE);
    core_idx_d   = core_idx;
    batch_idx_d  = batch_idx;
    snap_ld      = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    case (state)
      S_IDLE: if (start) batch_idx_d = '0;
      S_WAIT_END: if (flag_rise) begin
        snap_ld     = 1'b1;
        core_idx_d  = '0;
        mem_addr_d  = word_addr(batch_idx, CW'(0));
        mem_wdata_d = core_result[DATA_W-1:0];
      end
      S_WRITE: if (mem_ack && !last_core) begin
        core_idx_d  = core_inc;
        mem_addr_d  = word_addr(batch_idx, core_inc);
        mem_wdata_d = snap[core_inc];
      end
      S_NEXT: if (!last_batch) batch_idx_d = batch_idx + BW'(1);
      default: ;
    endcase
    if (!mem_wr_d) begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
  end

  // Registered outputs, indices, flag history and result snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_idx   <= '0;
      batch_idx  <= '0;
      flag_q     <= 1'b0;
      for (int k = 0; k < NUM_CORES; k++) snap[k] <= '0;
    end else begin
      core_start <= core_start_d;
      busy       <= busy_d;
      done       <= done_d;
      mem_wr     <= mem_wr_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      core_idx   <= core_idx_d;
      batch_idx  <= batch_idx_d;
      flag_q     <= state_ctrl_signal;
      if (snap_ld)
        for (int k = 0; k < NUM_CORES; k++) snap[k] <= core_result[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// tb_mem_ctrl_seq: drives mem_ctrl_seq with directed and random batches, checks writes against an expected-word queue.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// mem_ack is delayed, randomized or tied high depending on the step.
module tb_mem_ctrl_seq;
  localparam int NC = 4, DW = 16, AW = 8, BASE = 0, NB = 2, TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, flag, mem_ack;
  logic [NC*DW-1:0] core_result;
  logic             core_start, mem_wr, busy, done, err;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [0:0]       batch_idx;

  mem_ctrl_seq #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE),
                 .NUM_BATCHES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .state_ctrl_signal(flag),
    .core_result(core_result), .core_start(core_start), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_ack(mem_ack), .batch_idx(batch_idx),
    .busy(busy), .done(done), .err(err));

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected words for one batch: consecutive addresses from BASE + b*NC, data = per-core results at the flag edge.
  task automatic push_batch(input int b, input logic [NC*DW-1:0] r);
    wr_t w;
    for (int k = 0; k < NC; k++) begin
      w.a = AW'((BASE + b * NC + k) % (1 << AW));
      w.d = r[k*DW +: DW];
      exp_q.push_back(w);
    end
  endtask

  task automatic chk_outputs_zero(input string pre);
    chk({pre, "_core_start"}, core_start, 0);
    chk({pre, "_mem_addr"}, mem_addr, 0);
    chk({pre, "_mem_wdata"}, mem_wdata, 0);
    chk({pre, "_mem_wr"}, mem_wr, 0);
    chk({pre, "_batch_idx"}, batch_idx, 0);
    chk({pre, "_busy"}, busy, 0);
    chk({pre, "_done"}, done, 0);
    chk({pre, "_err"}, err, 0);
  endtask

  // One full start..done sequence. hold: keep flag high into the next batch; ackd: fixed ack delay;
  // rnd: random ack/start noise; fixed: use the directed result pattern and a 10-cycle flag delay.
  task automatic run(input bit hold, input int ackd, input bit rnd, input bit fixed);
    int dly, wcnt, ncs, nwr, bt, last_acc;
    bit pend, exp_next, a, fin;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wr_t w;
    dly = -1; wcnt = 0; ncs = 0; nwr = 0; bt = -1; last_acc = 0;
    pend = 0; exp_next = 0; fin = 0; pa = '0; pd = '0;
    exp_q.delete();
    @(negedge clk); start = 1'b1;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!fixed) core_result = {$urandom, $urandom};
      if (cyc == 0) chk("start_to_core_start", core_start, 1);
      chk("busy", busy, 1);
      chk("err_low", err, 0);
      // memory side
      if (exp_next) chk("wr_follows", mem_wr, 1);
      if (pend) begin
        chk("hold_wr", mem_wr, 1);
        chk("hold_addr", mem_addr, pa);
        chk("hold_data", mem_wdata, pd);
      end
      if (mem_wr) a = rnd ? ($urandom_range(0, 2) == 0) : (wcnt >= ackd);
      else        a = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      pend = 0; exp_next = 0;
      if (mem_wr && a) begin
        chk("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
        end
        nwr++; wcnt = 0; last_acc = cyc;
        exp_next = (exp_q.size() != 0);
      end else if (mem_wr) begin
        wcnt++; pend = 1; pa = mem_addr; pd = mem_wdata;
      end
      mem_ack = a;
      // core side
      if (core_start) begin
        ncs++; bt++;
        chk("batch_idx", batch_idx, bt);
        dly = fixed ? 11 : 4 + $urandom_range(0, 8);
        if (!hold) flag = 1'b0;
      end
      if (dly > 0) begin
        dly--;
        if (hold && dly == 1) flag = 1'b0;
        if (dly == 0) begin
          if (fixed) core_result = 64'h0044_0033_0022_0011;
          flag = 1'b1;
          push_batch(bt, core_result);
          exp_next = 1;
          dly = -1;
        end
      end
      if (done) begin
        fin = 1; start = 1'b0;
        chk("done_after_last_ack", cyc - last_acc, 2);
        chk("exp_drained", exp_q.size(), 0);
        chk("core_start_count", ncs, NB);
        chk("write_count", nwr, NB * NC);
      end
    end
    if (!fin) chk("run_timeout", fin, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_wr", mem_wr, 0);
    mem_ack = 1'b0;
  endtask

  // Reset while the third word (core_idx=2) is being presented.
  task automatic reset_mid();
    int dly, nacc;
    bit fired;
    dly = -1; nacc = 0; fired = 0;
    @(negedge clk); start = 1'b1; flag = 1'b0; mem_ack = 1'b1;
    for (int cyc = 0; cyc < 200 && !fired; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      core_result = {$urandom, $urandom};
      if (core_start) dly = 5;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin flag = 1'b1; dly = -1; end
      end
      if (mem_wr && nacc == 2) begin
        chk("mid_write_addr", mem_addr, 2);
        rst = 1'b1; fired = 1;
      end else if (mem_wr) nacc++;
    end
    if (!fired) chk("reset_mid_reached", fired, 1);
    @(negedge clk);
    chk_outputs_zero("mid_rst");
    rst = 1'b0; flag = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_quiet", mem_wr | busy, 0);
  endtask

`ifdef MEM_CTRL_SEQ_TIMEOUT_EN
  // Flag never rises: watchdog fires after TO cycles in WAIT_END, no writes, done pulses, err sticky.
  task automatic run_timeout();
    int c0, cdone, nwr;
    c0 = -1; cdone = -1; nwr = 0;
    @(negedge clk); start = 1'b1; flag = 1'b0; mem_ack = 1'b1;
    for (int cyc = 0; cyc < 300 && cdone < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (core_start && c0 < 0) c0 = cyc;
      if (mem_wr) nwr++;
      if (done) begin cdone = cyc; chk("to_err", err, 1); end
    end
    chk("to_done_delay", cdone - c0, TO + 1);
    chk("to_no_wr", nwr, 0);
    @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_idle", busy, 0);
    mem_ack = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; flag = 1'b0; mem_ack = 1'b0; core_result = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_outputs_zero("idle");

    run(0, 0, 0, 1);   // directed results, ack tied high
    run(0, 3, 0, 0);   // ack delayed 3 cycles per word
    run(1, 0, 0, 0);   // flag held high across batches
    run(1, 1, 1, 0);   // held flag with random ack/start noise
    for (int i = 0; i < 4; i++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1, 0);
    reset_mid();
    run(0, 0, 0, 1);   // clean restart from address 0
`ifdef MEM_CTRL_SEQ_TIMEOUT_EN
    run_timeout();
    run(0, 0, 0, 0);   // next start clears err
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
